fifo_vram_write_sequencer: RTL and testbench

- Drains the 16-bit BRAM-backed pseudo-FIFO (psuedofiforam) on its read side.
- Decodes each command as a pair of words, address first then data, and issues one VRAM write per pair through a req/ack handshake.
- Sits between the host-side FIFO and the framebuffer write port; it is the only master of the FIFO's read_en.

---
 rtl/fifo_seq_pkg.sv | 30 +++
 rtl/fifo_vram_write_sequencer.sv | 133 +++++++++++++
 tb/tb_fifo_vram_write_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_seq_pkg.sv
// Shared state encodings, width defaults and read-latency legality check for
// fifo_vram_write_sequencer.
package fifo_seq_pkg;

  localparam int SEQ_DATA_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP_A  = 3'd1;
  localparam logic [2:0] ST_WAIT_A = 3'd2;
  localparam logic [2:0] ST_POP_D  = 3'd3;
  localparam logic [2:0] ST_WAIT_D = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    POP_A  = ST_POP_A,
    WAIT_A = ST_WAIT_A,
    POP_D  = ST_POP_D,
    WAIT_D = ST_WAIT_D,
    WRITE  = ST_WRITE
  } seq_state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic bit read_lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/fifo_vram_write_sequencer.sv
// Drains address/data word pairs from the pseudo-FIFO and issues one VRAM write
// per pair. Optional macro SEQ_STREAM_EN adds a data-only streaming mode.
module fifo_vram_write_sequencer
  import fifo_seq_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = SEQ_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_valid,
  output logic              fifo_read_en,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  input  logic              vram_ack,
  output logic              idle,
  output logic [15:0]       cmd_count,
  output logic              err_spurious
`ifdef SEQ_STREAM_EN
  ,
  input  logic              stream_mode,
  input  logic [ADDR_W-1:0] stream_base
`endif
);

  localparam bit READ_LAT_OK = read_lat_legal(READ_LAT);

  generate
    if (!READ_LAT_OK) begin : g_bad_read_lat
      $error("fifo_vram_write_sequencer: READ_LAT must be 1 or 2");
    end
  endgenerate

  logic              stream_sel;
  logic [ADDR_W-1:0] stream_base_sel;

`ifdef SEQ_STREAM_EN
  assign stream_sel      = stream_mode;
  assign stream_base_sel = stream_base;
`else
  assign stream_sel      = 1'b0;
  assign stream_base_sel = '0;
`endif

  seq_state_t        state;
  logic              cmd_stream;
  logic [ADDR_W-1:0] stream_idx;

  wire in_wait = (state == WAIT_A) || (state == WAIT_D);

  // NOTE: every register here is updated with <= so all state advances together
  // on the clock edge; blocking assignments would make later lines see new values.
  // NOTE: the address/data holding registers are reset along with control so the
  // write port never shows stale values after an aborted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fifo_read_en <= 1'b0;
      vram_req     <= 1'b0;
      vram_addr    <= '0;
      vram_data    <= '0;
      cmd_count    <= '0;
      err_spurious <= 1'b0;
      idle         <= 1'b1;
      cmd_stream   <= 1'b0;
      stream_idx   <= '0;
    end else begin
      fifo_read_en <= 1'b0;
      if (fifo_valid && !in_wait) err_spurious <= 1'b1;

      // The pop strobe is registered: it is raised on the edge entering a POP
      // state, so in POP a high fifo_read_en means the pulse is issuing now.
      case (state)
        IDLE: begin
          if (!stream_sel) stream_idx <= '0;
          if (enable && !fifo_empty) begin
            fifo_read_en <= 1'b1;
            idle         <= 1'b0;
            cmd_stream   <= stream_sel;
            if (stream_sel) begin
              vram_addr <= stream_base_sel + stream_idx;
              state     <= POP_D;
            end else begin
              state <= POP_A;
            end
          end
        end
        POP_A: begin
          if (fifo_read_en) state <= WAIT_A;
          else              fifo_read_en <= !fifo_empty;
        end
        WAIT_A: begin
          if (fifo_valid) begin
            vram_addr    <= fifo_dout[ADDR_W-1:0];
            fifo_read_en <= !fifo_empty;
            state        <= POP_D;
          end
        end
        POP_D: begin
          if (fifo_read_en) state <= WAIT_D;
          else              fifo_read_en <= !fifo_empty;
        end
        WAIT_D: begin
          if (fifo_valid) begin
            vram_data <= fifo_dout;
            vram_req  <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (vram_ack) begin
            vram_req  <= 1'b0;
            cmd_count <= cmd_count + 16'd1;
            idle      <= 1'b1;
            state     <= IDLE;
            if (cmd_stream) stream_idx <= stream_idx + ADDR_W'(1);
          end
        end
        default: begin
          vram_req <= 1'b0;
          idle     <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_vram_write_sequencer.sv
// Scoreboard bench for fifo_vram_write_sequencer: a behavioural FIFO feeds the
// DUT, expected writes are queued by the stimulus and checked by a monitor.
module tb_fifo_vram_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_valid = 1'b0;
  logic        fifo_read_en;
  logic        vram_req;
  logic [15:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_ack = 1'b1;
  logic        idle;
  logic [15:0] cmd_count;
  logic        err_spurious;
`ifdef SEQ_STREAM_EN
  logic        stream_mode = 1'b0;
  logic [15:0] stream_base = '0;
`endif

  always #5 clk = ~clk;

  fifo_vram_write_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_valid   (fifo_valid),
    .fifo_read_en (fifo_read_en),
    .vram_req     (vram_req),
    .vram_addr    (vram_addr),
    .vram_data    (vram_data),
    .vram_ack     (vram_ack),
    .idle         (idle),
    .cmd_count    (cmd_count),
    .err_spurious (err_spurious)
`ifdef SEQ_STREAM_EN
    ,
    .stream_mode  (stream_mode),
    .stream_base  (stream_base)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: words[] written only by stimulus, rd_ptr only by the model.
  logic [15:0] words [64];
  int          n_pushed = 0;
  int          rd_ptr = 0;
  int          rd_pulses = 0;
  logic        inject = 1'b0;
  logic        pend_v = 1'b0;
  logic [15:0] pend_d = '0;
  logic        prev_rd = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fifo_valid = 1'b0;
        pend_v     = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        fifo_valid = pend_v | inject;
        fifo_dout  = pend_d;
        pend_v     = 1'b0;
        if (fifo_read_en) begin
          rd_pulses++;
          check("rd_while_empty", fifo_empty, 1'b0);
          check("rd_back_to_back", prev_rd, 1'b0);
          if (rd_ptr < n_pushed) begin
            pend_d = words[rd_ptr];
            rd_ptr++;
            pend_v = 1'b1;
          end
        end
        prev_rd = fifo_read_en;
      end
      fifo_empty = (rd_ptr == n_pushed);
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          len;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: compares each accepted write against the oldest expectation.
  logic        in_req = 1'b0;
  logic        unstable = 1'b0;
  int          req_len = 0;
  logic [15:0] held_addr = '0;
  logic [15:0] held_data = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_req = 1'b0;
      end else if (vram_req) begin
        if (!in_req) begin
          in_req    = 1'b1;
          req_len   = 0;
          unstable  = 1'b0;
          held_addr = vram_addr;
          held_data = vram_data;
        end else if (vram_addr !== held_addr || vram_data !== held_data) begin
          unstable = 1'b1;
        end
        req_len++;
        if (vram_ack) begin
          in_req = 1'b0;
          check("write_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("vram_addr", held_addr, e.addr);
            check("vram_data", held_data, e.data);
            check("req_cycles", req_len, e.len);
            check("addr_data_stable", unstable, 1'b0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    words[n_pushed] = w;
    n_pushed++;
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [15:0] d, input int len);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget);
    int n = 0;
    while (cmd_count !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("cmd_count", cmd_count, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_cnt;
  logic [6:0]  rd_vec, req_vec, idle_vec;
  int          base_rd, n, req_seen;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_en", fifo_read_en, 1'b0);
    check("rst_vram_req", vram_req, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_cmd_count", cmd_count, 16'd0);
    check("rst_err", err_spurious, 1'b0);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    enable = 1'b1;
    tick();

    // 1: back-to-back latency with both words present and ack tied high
    push(16'h0123);
    push(16'hA5A5);
    expect_write(16'h0123, 16'hA5A5, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rd_vec[i]   = fifo_read_en;
      req_vec[i]  = vram_req;
      idle_vec[i] = idle;
    end
    check("lat_read_en", rd_vec, 7'b0001010);
    check("lat_vram_req", req_vec, 7'b0100000);
    check("lat_idle", idle_vec, 7'b1000001);
    exp_cnt++;
    check("lat_cmd_count", cmd_count, exp_cnt);
    tick();

    // 2: data word arrives late; sequencer parks in POP_D without popping
    base_rd = rd_pulses;
    push(16'h0040);
    expect_write(16'h0040, 16'hBEEF, 1);
    repeat (10) tick();
    check("stall_pulses", rd_pulses - base_rd, 1);
    check("stall_not_idle", idle, 1'b0);
    check("stall_no_req", vram_req, 1'b0);
    push(16'hBEEF);
    exp_cnt++;
    wait_count(exp_cnt, 30);
    check("stall_total_pulses", rd_pulses - base_rd, 2);
    tick();

    // 3: ack held low for 7 cycles
    vram_ack = 1'b0;
    push(16'h1234);
    push(16'h5678);
    expect_write(16'h1234, 16'h5678, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vram_req && n < 40);
    check("ack_req_seen", vram_req, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    vram_ack = 1'b1;
    exp_cnt++;
    wait_count(exp_cnt, 10);
    repeat (4) tick();
    check("ack_single_inc", cmd_count, exp_cnt);

    // 4: enable dropped after the first pop of three queued pairs
    enable = 1'b0;
    tick();
    base_rd = rd_pulses;
    push(16'h0100); push(16'h1111);
    push(16'h0200); push(16'h2222);
    push(16'h0300); push(16'h3333);
    expect_write(16'h0100, 16'h1111, 1);
    expect_write(16'h0200, 16'h2222, 1);
    expect_write(16'h0300, 16'h3333, 1);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_pulses == base_rd && n < 20);
    tick();
    enable = 1'b0;
    exp_cnt++;
    wait_count(exp_cnt, 30);
    repeat (8) tick();
    check("en_off_idle", idle, 1'b1);
    check("en_off_words_left", n_pushed - rd_ptr, 4);
    check("en_off_cmd_count", cmd_count, exp_cnt);
    enable = 1'b1;
    exp_cnt += 16'd2;
    wait_count(exp_cnt, 40);
    check("en_on_drained", n_pushed - rd_ptr, 0);
    tick();

    // 5: asynchronous reset during WAIT_D, then spurious valid in IDLE
    base_rd = rd_pulses;
    push(16'h0777);
    push(16'h0888);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_pulses < base_rd + 2 && n < 20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_vram_req", vram_req, 1'b0);
    check("arst_read_en", fifo_read_en, 1'b0);
    check("arst_vram_addr", vram_addr, 16'h0000);
    check("arst_vram_data", vram_data, 16'h0000);
    check("arst_cmd_count", cmd_count, 16'h0000);
    check("arst_idle", idle, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vram_req) req_seen++;
    end
    check("post_rst_no_req", req_seen, 0);
    check("post_rst_err", err_spurious, 1'b0);
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (2) tick();
    check("spurious_set", err_spurious, 1'b1);
    repeat (5) tick();
    check("spurious_sticky", err_spurious, 1'b1);
    check("spurious_idle", idle, 1'b1);
    check("spurious_no_cmd", cmd_count, 16'd0);
    exp_cnt = 16'd0;

`ifdef SEQ_STREAM_EN
    // 6: streaming mode with address wrap at 2^ADDR_W
    stream_mode = 1'b1;
    stream_base = 16'hFFFE;
    tick();
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    expect_write(16'hFFFE, 16'h1111, 1);
    expect_write(16'hFFFF, 16'h2222, 1);
    expect_write(16'h0000, 16'h3333, 1);
    exp_cnt += 16'd3;
    wait_count(exp_cnt, 60);
    tick();
    stream_mode = 1'b0;
    tick();
`endif

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
